// File: rtl/forward_stall_controller.sv
// forward_stall_controller
//   Hazard unit for a 5-stage in-order pipeline. It keeps shadow records of
//   the instructions in EX, MEM and WB, and it produces the following:
//   - operand forwarding selects for EX,
//   - a one-cycle load-use stall/bubble,
//   - a pipeline flush on a taken branch,
//   - saturating stall and flush event counters.
//
// Ports
//   clk                  rising-edge clock
//   reset                synchronous active-low reset
//   id_valid_i           ID holds a real instruction
//   id_rs1_i, id_rs2_i   ID source registers
//   id_rd_i              ID destination register
//   id_reg_write_i       ID writes a register
//   id_mem_read_i        ID is a load
//   ex_branch_taken_i    EX branch/jump resolved taken
//   fwd_a_wb_sel_o       operand A forwarding select, WB source
//   fwd_a_mem_sel_o      operand A forwarding select, MEM source
//   fwd_b_wb_sel_o       operand B forwarding select, WB source
//   fwd_b_mem_sel_o      operand B forwarding select, MEM source
//   stall_o              freeze PC and IF/ID
//   bubble_o             load a NOP into ID/EX
//   flush_o              clear IF/ID and ID/EX
//   state_o              00 RUN, 01 STALL, 10 FLUSH
//   stall_cnt_o          stall event counter
//   flush_cnt_o          flush event counter
module forward_stall_controller #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid_i,
   input  logic [REG_AW-1:0] id_rs1_i,
   input  logic [REG_AW-1:0] id_rs2_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic              id_reg_write_i,
   input  logic              id_mem_read_i,
   input  logic              ex_branch_taken_i,
   output logic              fwd_a_wb_sel_o,
   output logic              fwd_a_mem_sel_o,
   output logic              fwd_b_wb_sel_o,
   output logic              fwd_b_mem_sel_o,
   output logic              stall_o,
   output logic              bubble_o,
   output logic              flush_o,
   output logic [1:0]        state_o,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output logic [CNT_W-1:0]  flush_cnt_o
);

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
      logic              reg_write;
      logic              mem_read;
   } stage_t;

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_STALL = 2'b01,
      ST_FLUSH = 2'b10
   } state_t;

   stage_t           r_ex, r_mem, r_wb;
   stage_t           w_id;
   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
   logic             w_load_use;
   logic             w_flush;
   logic             w_stall;

   // A stage produces a value for register r. Writes to x0 never count.
   function automatic logic f_hit(input stage_t s, input logic [REG_AW-1:0] r);
      return s.valid & s.reg_write & (s.rd != '0) & (s.rd == r);
   endfunction

   assign w_id = '{valid:     id_valid_i,
                   rs1:       id_rs1_i,
                   rs2:       id_rs2_i,
                   rd:        id_rd_i,
                   reg_write: id_reg_write_i,
                   mem_read:  id_mem_read_i};

   // Pipeline shadow records. A stalled or flushed ID slot enters EX as a
   // bubble. The ID instruction itself stays in the IF/ID register, which
   // is frozen by stall_o.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_ex  <= '0;
         r_mem <= '0;
         r_wb  <= '0;
      end else begin
         r_wb  <= r_mem;
         r_mem <= r_ex;
         if (w_stall || w_flush) r_ex.valid <= 1'b0;
         else                    r_ex       <= w_id;
      end
   end

   // Forwarding selects. MEM and WB are reported independently. The
   // datapath chains the two muxes, which gives MEM priority when both
   // stages hit.
   assign fwd_a_mem_sel_o = r_ex.valid & f_hit(r_mem, r_ex.rs1);
   assign fwd_a_wb_sel_o  = r_ex.valid & f_hit(r_wb,  r_ex.rs1);
   assign fwd_b_mem_sel_o = r_ex.valid & f_hit(r_mem, r_ex.rs2);
   assign fwd_b_wb_sel_o  = r_ex.valid & f_hit(r_wb,  r_ex.rs2);

   assign w_load_use = id_valid_i & r_ex.valid & r_ex.mem_read & r_ex.reg_write &
                       (r_ex.rd != '0) & ((r_ex.rd == id_rs1_i) | (r_ex.rd == id_rs2_i));
   assign w_flush    = ex_branch_taken_i & r_ex.valid;
   assign w_stall    = w_load_use & ~w_flush;

   assign flush_o  = w_flush;
   assign stall_o  = w_stall;
   assign bubble_o = w_stall;

   // FSM: state register
   always_ff @(posedge clk) begin
      if (!reset) r_state <= ST_RUN;
      else        r_state <= w_state_nxt;
   end

   // FSM: next state
   always_comb begin
      w_state_nxt = ST_RUN;
      if (w_flush)      w_state_nxt = ST_FLUSH;
      else if (w_stall) w_state_nxt = ST_STALL;
   end

   // FSM: outputs
   always_comb begin
      state_o = r_state;
   end

   // Saturating event counters
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign stall_cnt_o = r_stall_cnt;
   assign flush_cnt_o = r_flush_cnt;

   // Record fields that are carried along for completeness but not consumed
   logic w_unused;
   assign w_unused = ^{r_mem.rs1, r_mem.rs2, r_mem.mem_read,
                       r_wb.rs1,  r_wb.rs2,  r_wb.mem_read};

endmodule

// File: tb/tb_forward_stall_controller.sv
module tb_forward_stall_controller;
   localparam int AW = 5;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          id_valid_i = 1'b0;
   logic [AW-1:0] id_rs1_i = '0, id_rs2_i = '0, id_rd_i = '0;
   logic          id_reg_write_i = 1'b0, id_mem_read_i = 1'b0;
   logic          ex_branch_taken_i = 1'b0;
   logic          fwd_a_wb_sel_o, fwd_a_mem_sel_o, fwd_b_wb_sel_o, fwd_b_mem_sel_o;
   logic          stall_o, bubble_o, flush_o;
   logic [1:0]    state_o;
   logic [CW-1:0] stall_cnt_o, flush_cnt_o;

   forward_stall_controller #(.REG_AW(AW), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
      .id_rd_i(id_rd_i), .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i),
      .ex_branch_taken_i(ex_branch_taken_i),
      .fwd_a_wb_sel_o(fwd_a_wb_sel_o), .fwd_a_mem_sel_o(fwd_a_mem_sel_o),
      .fwd_b_wb_sel_o(fwd_b_wb_sel_o), .fwd_b_mem_sel_o(fwd_b_mem_sel_o),
      .stall_o(stall_o), .bubble_o(bubble_o), .flush_o(flush_o), .state_o(state_o),
      .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o));

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: the instruction occupying each of EX, MEM and WB
   typedef struct {
      bit v;
      int rs1, rs2, rd;
      bit rw, mr;
   } ins_t;

   ins_t m_ex, m_mem, m_wb;
   ins_t nop_i = '{0, 0, 0, 0, 0, 0};
   int   m_state = 0;
   int   m_scnt = 0, m_fcnt = 0;
   bit   last_stall = 0;

   function automatic bit produces(input ins_t s, input int r);
      return s.v && s.rw && s.rd != 0 && s.rd == r;
   endfunction

   // One clock cycle: drive ID at the negedge, check outputs, then advance
   // the model at the posedge.
   task automatic step(input bit rst_n, input ins_t id, input bit br);
      bit e_flush, e_stall, lu;
      @(negedge clk);
      reset = rst_n;
      id_valid_i = id.v;
      id_rs1_i = AW'(id.rs1);
      id_rs2_i = AW'(id.rs2);
      id_rd_i = AW'(id.rd);
      id_reg_write_i = id.rw;
      id_mem_read_i = id.mr;
      ex_branch_taken_i = br;
      #1;
      lu = id.v && m_ex.v && m_ex.mr && produces(m_ex, id.rs1);
      lu = lu || (id.v && m_ex.v && m_ex.mr && produces(m_ex, id.rs2));
      e_flush = br && m_ex.v;
      e_stall = lu && !e_flush;
      chk("fwd_a_mem", fwd_a_mem_sel_o, m_ex.v && produces(m_mem, m_ex.rs1));
      chk("fwd_a_wb",  fwd_a_wb_sel_o,  m_ex.v && produces(m_wb,  m_ex.rs1));
      chk("fwd_b_mem", fwd_b_mem_sel_o, m_ex.v && produces(m_mem, m_ex.rs2));
      chk("fwd_b_wb",  fwd_b_wb_sel_o,  m_ex.v && produces(m_wb,  m_ex.rs2));
      chk("flush", flush_o, e_flush);
      chk("stall", stall_o, e_stall);
      chk("bubble", bubble_o, e_stall);
      chk("state", state_o, m_state);
      chk("stall_cnt", stall_cnt_o, m_scnt);
      chk("flush_cnt", flush_cnt_o, m_fcnt);
      @(posedge clk);
      if (!rst_n) begin
         m_ex = nop_i; m_mem = nop_i; m_wb = nop_i;
         m_state = 0; m_scnt = 0; m_fcnt = 0;
         last_stall = 0;
      end else begin
         m_wb = m_mem;
         m_mem = m_ex;
         if (e_stall || e_flush) m_ex.v = 0;
         else m_ex = id;
         m_state = e_flush ? 2 : (e_stall ? 1 : 0);
         if (e_stall && m_scnt < CMAX) m_scnt++;
         if (e_flush && m_fcnt < CMAX) m_fcnt++;
         last_stall = e_stall;
      end
   endtask

   function automatic ins_t alu(input int rd, input int rs1, input int rs2);
      return '{1, rs1, rs2, rd, 1, 0};
   endfunction

   function automatic ins_t ld(input int rd, input int rs1);
      return '{1, rs1, 0, rd, 1, 1};
   endfunction

   initial begin
      ins_t r;
      m_ex = nop_i; m_mem = nop_i; m_wb = nop_i;

      // Reset with live inputs; everything must read zero
      step(0, alu(5, 1, 2), 1);
      step(0, alu(5, 1, 2), 1);
      #1;
      chk("rst_state", state_o, 0);
      chk("rst_fwd", fwd_a_mem_sel_o, 0);

      // add x5 then sub x6,x5,x7: MEM forwarding on A
      step(1, alu(5, 1, 2), 0);
      step(1, alu(6, 5, 7), 0);
      #2;
      chk("r037_a_mem", fwd_a_mem_sel_o, 1);
      chk("r037_b_mem", fwd_b_mem_sel_o, 0);
      chk("r037_b_wb", fwd_b_wb_sel_o, 0);

      // lw x5 then add x6,x1,x5: one stall, then WB forwarding on B
      step(1, ld(5, 1), 0);
      step(1, alu(6, 1, 5), 0);
      #2;
      chk("r038_state", state_o, 1);
      chk("r038_scnt", stall_cnt_o, 1);
      step(1, alu(6, 1, 5), 0);
      #2;
      chk("r038_b_wb", fwd_b_wb_sel_o, 1);
      chk("r038_state_run", state_o, 0);

      // Writers of x3 in MEM and WB, reader of x3 in EX
      step(1, alu(3, 1, 1), 0);
      step(1, alu(3, 2, 2), 0);
      step(1, alu(9, 3, 4), 0);
      #2;
      chk("r039_a_mem", fwd_a_mem_sel_o, 1);
      chk("r039_a_wb", fwd_a_wb_sel_o, 1);

      // Taken branch during a load-use: flush wins
      step(1, ld(5, 1), 0);
      step(1, alu(6, 5, 1), 1);
      #2;
      chk("r040_state", state_o, 2);
      chk("r040_fcnt", flush_cnt_o, 1);
      chk("r040_scnt", stall_cnt_o, 1);

      // x0 never forwards or stalls
      step(1, ld(0, 1), 0);
      step(1, alu(7, 0, 0), 0);
      #2;
      chk("r041_state", state_o, 0);
      step(1, alu(8, 0, 0), 0);
      #2;
      chk("r041_a", fwd_a_mem_sel_o | fwd_a_wb_sel_o, 0);

      // Saturation: 18 more load-use stalls against a 4-bit counter
      for (int i = 0; i < 18; i++) begin
         step(1, ld(5, 1), 0);
         step(1, alu(6, 5, 5), 0);
         step(1, alu(6, 5, 5), 0);
      end
      #2;
      chk("r042_sat", stall_cnt_o, CMAX);

      // Reset on a stall cycle aborts it
      step(1, ld(5, 1), 0);
      step(0, alu(6, 5, 5), 0);
      #2;
      chk("r042_rst_stall", stall_o, 0);
      chk("r042_rst_scnt", stall_cnt_o, 0);
      chk("r042_rst_fcnt", flush_cnt_o, 0);

      // Randomized traffic over a small register set; a stalled ID is held
      r = nop_i;
      for (int i = 0; i < 400; i++) begin
         if (!last_stall) begin
            r.v = ($urandom_range(0, 5) != 0);
            r.rs1 = $urandom_range(0, 3);
            r.rs2 = $urandom_range(0, 3);
            r.rd = $urandom_range(0, 3);
            r.rw = ($urandom_range(0, 3) != 0);
            r.mr = r.rw && ($urandom_range(0, 1) != 0);
         end
         step(($urandom_range(0, 40) != 0), r, ($urandom_range(0, 7) == 0));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/forward_stall_controller.md
FORWARD_STALL_CONTROLLER -- requirements
Module: forward_stall_controller

Interface
REQ-001 The block SHALL have parameter REG_AW, default 5, giving the register-address width.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the performance-counter width.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-low reset.
REQ-006 id_valid_i  input  1  ID stage holds a real instruction.
REQ-007 id_rs1_i, id_rs2_i  input  REG_AW each  ID source registers.
REQ-008 id_rd_i  input  REG_AW  ID destination register.
REQ-009 id_reg_write_i, id_mem_read_i  input  1 each  ID writes a register / ID is a load.
REQ-010 ex_branch_taken_i  input  1  EX-stage branch or jump resolved taken.
REQ-011 fwd_a_wb_sel_o, fwd_a_mem_sel_o  output  1 each  operand A forwarding-mux selects.
REQ-012 fwd_b_wb_sel_o, fwd_b_mem_sel_o  output  1 each  operand B forwarding-mux selects.
REQ-013 stall_o  output  1  freeze PC and IF/ID.
REQ-014 bubble_o  output  1  load NOP into ID/EX.
REQ-015 flush_o  output  1  clear IF/ID and ID/EX.
REQ-016 state_o  output  2  FSM state: 00 RUN, 01 STALL, 10 FLUSH.
REQ-017 stall_cnt_o, flush_cnt_o  output  CNT_W each  event counters.

Function
REQ-018 The block SHALL keep three stage records EX, MEM, WB, each holding {valid, rs1, rs2, rd, reg_write, mem_read}, updated every clock.
REQ-019 Each clock: WB <= MEM; MEM <= EX; EX <= ID inputs if no stall and no flush, else EX.valid <= 0.
REQ-020 Let hit(S, r) = S.valid & S.reg_write & (S.rd != 0) & (S.rd == r).
REQ-021 fwd_a_mem_sel_o = hit(MEM, EX.rs1); fwd_a_wb_sel_o = hit(WB, EX.rs1); fwd_b_* use EX.rs2; all are combinational from the records, with zero latency.
REQ-022 Selects SHALL drive two chained 2:1 muxes (regfile/WB first, then that/MEM), so MEM has priority when both hit; the block SHALL NOT gate either select on the other.
REQ-023 The selects SHALL be 0 when EX.valid = 0.
REQ-024 load_use = id_valid_i & EX.valid & EX.mem_read & EX.reg_write & (EX.rd != 0) & (EX.rd == id_rs1_i | EX.rd == id_rs2_i).
REQ-025 flush_o = ex_branch_taken_i & EX.valid, combinational.
REQ-026 stall_o = bubble_o = load_use & ~flush_o, combinational; flush wins over stall in the same cycle.
REQ-027 A load-use stall SHALL last exactly one cycle; the consumer then enters EX with the load in WB, and WB forwarding is selected.
REQ-028 FSM next state SHALL be: FLUSH if flush_o; else STALL if stall_o; else RUN, from any state.
REQ-029 stall_o SHALL NOT be asserted in two consecutive cycles for the same ID instruction; this follows from REQ-019 and REQ-024.
REQ-030 stall_cnt_o SHALL increment on each cycle with stall_o = 1, saturating at all-ones.
REQ-031 flush_cnt_o SHALL increment on each cycle with flush_o = 1, saturating at all-ones.
REQ-032 Register x0 SHALL never cause forwarding or a stall.

Reset
REQ-033 With reset = 0 at a rising clk edge, all record valid bits SHALL be 0, state SHALL be RUN, and both counters SHALL be 0.
REQ-034 During reset all outputs SHALL read 0, since they derive from the cleared records.
REQ-035 Reset asserted mid-stall or mid-flush SHALL abort that action on the same edge.
REQ-036 The first edge after reset = 1 SHALL capture ID normally.

Verification
REQ-037 add x5 in EX, then sub x6,x5,x7 in ID -> next cycle fwd_a_mem_sel_o = 1, fwd_b_* = 0, stall_o = 0.
REQ-038 lw x5 in EX, add x6,x1,x5 in ID -> stall_o = bubble_o = 1 for 1 cycle, state_o = 01, stall_cnt_o = 1; next cycle add is in EX with fwd_b_wb_sel_o = 1.
REQ-039 Writers of x3 in MEM and in WB, with EX reading x3 on rs1 -> fwd_a_mem_sel_o = 1 and fwd_a_wb_sel_o = 1.
REQ-040 ex_branch_taken_i = 1 while a load-use on ID also holds -> flush_o = 1, stall_o = 0, state_o = 10 next cycle, flush_cnt_o += 1, EX.valid = 0 next cycle.
REQ-041 Writer rd = x0 followed by a reader of x0 -> all selects 0, no stall.
REQ-042 Counter preset to all-ones then 3 further stalls -> stall_cnt_o holds all-ones; reset = 0 mid-stall -> stall_o = 0 and counters 0 after the edge.
